data_memory_pipe: RTL

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

---
 rtl/data_memory_pipe.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_pipe.sv
// ----------------------------------------------------------------------------
// data_memory_pipe
//
// Word-organised data memory with a valid/ready request channel and a
// valid/ready response channel. Only one request may be in flight at a time.
// Loads return a byte, a half-word or a word, zero- or sign-extended. Stores
// write only the byte lanes that the access covers.
//
// Stores are committed on the accept edge. Load data is also sampled on the
// accept edge. The response is then presented after a fixed, parameterised
// latency and is held until the consumer takes it.
//
// Parameters
//   DATA_WIDTH    : data word width (only 32 is supported)
//   MEM_ADDR_SIZE : log2 of memory depth in words
//   LATENCY       : accept-to-response latency in cycles, 1..8
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (high only when idle)
//   req_write  in   1 = store, 0 = load
//   maskmode   in   00 byte, 01 half, 1x word
//   sext       in   load extension: 1 = sign, 0 = zero
//   address    in   byte address (upper bits beyond the memory wrap around)
//   write_data in   store data, right-aligned
//   resp_valid out  response present
//   resp_ready in   consumer accepts the response
//   read_data  out  load result, 0 for stores
//   resp_err   out  misaligned-access flag
//
// Optional feature (macro DMEM_MISALIGN_TRAP_EN)
//   When the macro is defined, a misaligned half or word access is flagged
//   with resp_err=1. Its store is suppressed and it returns read_data=0.
//   When the macro is undefined, resp_err stays 0 and a misaligned access is
//   aligned down to its natural boundary.
// ----------------------------------------------------------------------------
module data_memory_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_SIZE = 8,
    parameter int LATENCY       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            maskmode,
    input  logic                  sext,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  resp_err
);

    localparam int DEPTH = 1 << MEM_ADDR_SIZE;

    // WAIT is left when the counter reaches zero. It therefore starts at
    // LATENCY-2, which gives LATENCY-1 cycles in WAIT.
    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    logic [3:0] count;

    logic [31:0] mem [DEPTH];

    logic                     accept;
    logic [MEM_ADDR_SIZE-1:0] index;
    logic [1:0]               lane;
    logic                     is_byte;
    logic                     is_half;
    logic                     trap;
    logic [3:0]               byte_en;
    logic [31:0]              lane_data;
    logic [31:0]              mem_word;
    logic [7:0]               load_byte;
    logic [15:0]              load_half;
    logic [31:0]              load_result;
    logic [31:0]              resp_data_next;
    logic [31:0]              pend_data;
    logic                     pend_err;

    // Address bits above the memory are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[DATA_WIDTH-1:MEM_ADDR_SIZE+2];

    // Gate with rst so that no store can be committed while reset is held.
    assign accept  = req_valid && req_ready && !rst;
    assign index   = address[MEM_ADDR_SIZE+1:2];
    assign lane    = address[1:0];
    assign is_byte = (maskmode == 2'b00);
    assign is_half = (maskmode == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
    // Word accesses are maskmode 1x, so only lane 0 is aligned for them.
    assign trap = (is_half && lane[0]) || (maskmode[1] && (lane != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Byte enables and replicated store data. Half and word accesses ignore
    // the low address bits, which aligns a misaligned access down.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = write_data[31:0];
        if (is_byte) begin
            byte_en   = 4'b0001 << lane;
            lane_data = {4{write_data[7:0]}};
        end else if (is_half) begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{write_data[15:0]}};
        end
    end

    assign mem_word = mem[index];

    // Pick the addressed lane out of the stored word and extend it.
    always_comb begin
        load_byte = mem_word[7:0];
        case (lane)
            2'd0:    load_byte = mem_word[7:0];
            2'd1:    load_byte = mem_word[15:8];
            2'd2:    load_byte = mem_word[23:16];
            default: load_byte = mem_word[31:24];
        endcase
        load_half = lane[1] ? mem_word[31:16] : mem_word[15:0];

        if (is_byte) begin
            load_result = sext ? {{24{load_byte[7]}}, load_byte}
                               : {24'd0, load_byte};
        end else if (is_half) begin
            load_result = sext ? {{16{load_half[15]}}, load_half}
                               : {16'd0, load_half};
        end else begin
            load_result = mem_word;
        end

        resp_data_next = (req_write || trap) ? 32'd0 : load_result;
    end

    // Memory has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !trap) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[index][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Request/response sequencing. All handshake outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            read_data  <= '0;
            resp_err   <= 1'b0;
            pend_data  <= 32'd0;
            pend_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        pend_data <= resp_data_next;
                        pend_err  <= trap;
                        if (LATENCY <= 1) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            read_data  <= resp_data_next;
                            resp_err   <= trap;
                        end else begin
                            state <= S_WAIT;
                            count <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (count == 4'd0) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        read_data  <= pend_data;
                        resp_err   <= pend_err;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        read_data  <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    count      <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    read_data  <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
